// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: PC generator, single-outstanding imem port and
// an in-order prefetch queue that presents one {PC, PC+4, Inst} word to ID.
module if_prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       Clk,
  input  logic                       Clrn,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_PC,
  output logic [XLEN-1:0]            out_PC4,
  output logic [31:0]                out_Inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            busy_q, busy_d;
  logic            drop_q, drop_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_d [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     inst_mem_d [DEPTH];

  logic            resp;
  logic            issue;
  logic            push;
  logic            pop;
  logic            head_valid;
  logic [CW:0]     occ;

  always_comb begin
    // A strobe with nothing outstanding (e.g. left over from before reset) is ignored.
    resp       = imem_rvalid & busy_q;
    occ        = {1'b0, count_q} + {{CW{1'b0}}, busy_q};
    issue      = Clrn & ~redirect & (~busy_q | resp) & (occ < DEPTH_W);
    head_valid = (count_q != '0);
    pop        = head_valid & ~stall & ~redirect;
    push       = resp & ~drop_q & ~redirect;

    fpc_d      = fpc_q;
    req_pc_d   = req_pc_q;
    busy_d     = busy_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;

    if (resp) drop_d = 1'b0;

    if (issue) begin
      fpc_d    = fpc_q + XLEN'(4);
      req_pc_d = fpc_q;
      busy_d   = 1'b1;
    end else if (resp) begin
      busy_d = 1'b0;
    end

    if (redirect) begin
      fpc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      // The in-flight fetch belongs to the old path; swallow it when it lands.
      if (busy_q & ~resp) drop_d = 1'b1;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = req_pc_q;
        inst_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      fpc_q      <= RESET_PC;
      req_pc_q   <= '0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pc_mem_q   <= '{default: '0};
      inst_mem_q <= '{default: '0};
    end else begin
      fpc_q      <= fpc_d;
      req_pc_q   <= req_pc_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = fpc_q;
  assign count     = count_q;
  assign out_valid = head_valid;
  assign out_PC    = head_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign out_PC4   = head_valid ? pc_mem_q[rd_ptr_q] + XLEN'(4) : '0;
  assign out_Inst  = head_valid ? inst_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: per-cycle queue-based reference model plus
// directed scenarios and a randomized stall/redirect/latency run.
module tb_if_prefetch_queue;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_PC;
  logic [31:0] out_PC4;
  logic [31:0] out_Inst;
  logic [2:0]  count;

  if_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .Clk(Clk), .Clrn(Clrn), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_PC(out_PC), .out_PC4(out_PC4), .out_Inst(out_Inst), .count(count)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // reference model: entries are {pc, inst}
  logic [63:0] m_q[$];
  logic [31:0] m_fpc, m_req_pc;
  logic        m_busy, m_drop;

  // memory model
  logic        pend_v = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_due = 0;
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1;
  logic        last_req;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return ~a ^ 32'h0F0F_0000;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_fpc = RPC; m_req_pc = '0; m_busy = 1'b0; m_drop = 1'b0;
    pend_v = 1'b0;
  endtask

  task automatic do_reset();
    stall = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0;
    Clrn = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
    checks++; if (out_PC !== 32'h0 || out_PC4 !== 32'h0 || out_Inst !== 32'h0) begin
      failures++; $display("FAIL rst_out got=%h/%h/%h exp=0/0/0", out_PC, out_PC4, out_Inst); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    @(posedge Clk); #1;
    model_reset();
    Clrn = 1'b1;
  endtask

  // One clock cycle: drive inputs, check request, advance model, check outputs.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc, input logic stale);
    logic        rv, rv_eff, exp_req;
    logic [31:0] ep, ei;
    stall = s; redirect = r; redirect_pc = rpc;
    rv = stale || (pend_v && cyc == pend_due);
    imem_rvalid = rv;
    imem_rdata  = stale ? 32'hBAD0_BAD0 : (pend_v ? mem_data(pend_addr) : 32'h0);
    @(negedge Clk);
    rv_eff  = rv && m_busy;
    exp_req = !r && (!m_busy || rv_eff) && (m_q.size() + (m_busy ? 1 : 0) < DEPTH);
    checks++;
    if (imem_req !== exp_req) begin
      failures++; $display("FAIL req cyc=%0d got=%0b exp=%0b", cyc, imem_req, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (imem_addr !== m_fpc) begin
        failures++; $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_fpc);
      end
    end
    @(posedge Clk);
    last_req = imem_req; last_addr = imem_addr;
    if (rv && !stale) pend_v = 1'b0;
    if (imem_req === 1'b1) begin
      pend_v = 1'b1; pend_addr = imem_addr;
      pend_due = cyc + int'($urandom_range(lat_max, lat_min));
    end
    if (r) begin
      m_q.delete();
      if (rv_eff) m_drop = 1'b0;
      else if (m_busy) m_drop = 1'b1;
      if (rv_eff) m_busy = 1'b0;
      m_fpc = {rpc[31:2], 2'b00};
    end else begin
      if (m_q.size() > 0 && !s) void'(m_q.pop_front());
      if (rv_eff) begin
        if (m_drop) m_drop = 1'b0;
        else m_q.push_back({m_req_pc, imem_rdata});
      end
      if (exp_req) begin m_req_pc = m_fpc; m_fpc = m_fpc + 32'd4; m_busy = 1'b1; end
      else if (rv_eff) m_busy = 1'b0;
    end
    cyc++;
    #1;
    checks++;
    if (count !== 3'(m_q.size())) begin
      failures++; $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, count, m_q.size());
    end
    ep = (m_q.size() > 0) ? m_q[0][63:32] : 32'h0;
    ei = (m_q.size() > 0) ? m_q[0][31:0]  : 32'h0;
    checks++;
    if (out_valid !== (m_q.size() > 0)) begin
      failures++; $display("FAIL valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, m_q.size() > 0);
    end
    checks++;
    if (out_PC !== ep || out_Inst !== ei || out_PC4 !== ((m_q.size() > 0) ? ep + 32'd4 : 32'h0)) begin
      failures++; $display("FAIL head cyc=%0d got=%h/%h/%h exp_pc=%h exp_inst=%h", cyc, out_PC, out_PC4, out_Inst, ep, ei);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_sequential();
    logic [31:0] a [3];
    logic        q [3];
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      if (i < 3) begin a[i] = last_addr; q[i] = last_req; end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q[i] !== 1'b1 || a[i] !== RPC + 32'(4 * i)) begin
        failures++; $display("FAIL seq_addr%0d got=%0b/%h exp=1/%h", i, q[i], a[i], RPC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall_full();
    logic        seen;
    logic [31:0] first_addr;
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b0);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
    checks++; if (last_req !== 1'b0) begin failures++; $display("FAIL full_req got=%0b exp=0", last_req); end
    seen = 1'b0; first_addr = '0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_PC !== RPC + 32'(4 * k)) begin
        failures++; $display("FAIL pop_order%0d got=%h exp=%h", k, out_PC, RPC + 32'(4 * k));
      end
      step(1'b0, 1'b0, '0, 1'b0);
      if (!seen && last_req === 1'b1) begin seen = 1'b1; first_addr = last_addr; end
    end
    checks++;
    if (!seen || first_addr !== 32'h110) begin
      failures++; $display("FAIL resume_addr got=%0b/%h exp=1/00000110", seen, first_addr);
    end
  endtask

  task automatic test_redirect_drop();
    logic        seen;
    logic [31:0] a;
    do_reset();
    lat_min = 3; lat_max = 3;
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h203, 1'b0);
    checks++; if (last_req !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL drop_redir got=%0b/%0b exp=0/0", last_req, out_valid); end
    seen = 1'b0; a = '0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      if (last_req === 1'b1) begin seen = 1'b1; a = last_addr; end
    end
    checks++; if (!seen || a !== 32'h200) begin
      failures++; $display("FAIL drop_newaddr got=%0b/%h exp=1/00000200", seen, a); end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || out_PC !== 32'h200) begin
      failures++; $display("FAIL drop_first got=%0b/%h exp=1/00000200", seen, out_PC); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b0);
    checks++; if (!(pend_v && pend_due == cyc)) begin
      failures++; $display("FAIL rr_setup got=%0b exp=1", pend_v); end
    step(1'b0, 1'b1, 32'h300, 1'b0);
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL rr_flush got=%0b/%0d exp=0/0", out_valid, count); end
    step(1'b0, 1'b0, '0, 1'b0);
    checks++; if (last_req !== 1'b1 || last_addr !== 32'h300) begin
      failures++; $display("FAIL rr_next got=%0b/%h exp=1/00000300", last_req, last_addr); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_push_pop();
    logic reached;
    do_reset();
    lat_min = 1; lat_max = 1;
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      step(1'b1, 1'b0, '0, 1'b0);
      if (count === 3'd2) reached = 1'b1;
    end
    checks++; if (!reached) begin failures++; $display("FAIL pp_reach got=%0d exp=2", count); end
    step(1'b0, 1'b0, '0, 1'b0);
    checks++; if (count !== 3'd2 || out_PC !== 32'h104) begin
      failures++; $display("FAIL pp_same got=%0d/%h exp=2/00000104", count, out_PC); end
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_wrap();
    logic [31:0] a [2];
    int          n;
    logic        seen;
    do_reset();
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    n = 0; seen = 1'b0; a[0] = '0; a[1] = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      if (last_req === 1'b1 && n < 2) begin a[n] = last_addr; n++; end
      if (!seen && out_valid === 1'b1 && out_PC === 32'hFFFF_FFFC) begin
        seen = 1'b1;
        checks++;
        if (out_PC4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=00000000", out_PC4); end
      end
    end
    checks++; if (n < 2 || a[0] !== 32'hFFFF_FFFC || a[1] !== 32'h0) begin
      failures++; $display("FAIL wrap_addr got=%0d/%h/%h exp=2/fffffffc/00000000", n, a[0], a[1]); end
    checks++; if (!seen) begin failures++; $display("FAIL wrap_seen got=0 exp=1"); end
  endtask

  task automatic test_reset_midreq();
    logic seen;
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1 & (i == 0), RPC, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, '0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mr_setup got=%0b exp=1", out_valid); end
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1);
    checks++; if (last_req !== 1'b1 || last_addr !== RPC) begin
      failures++; $display("FAIL mr_restart got=%0b/%h exp=1/%h", last_req, last_addr, RPC); end
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || out_PC !== RPC || out_Inst !== mem_data(RPC)) begin
      failures++; $display("FAIL mr_first got=%0b/%h/%h exp=1/%h/%h", seen, out_PC, out_Inst, RPC, mem_data(RPC)); end
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 10) < 3, ($urandom % 20) == 0, $urandom, 1'b0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall_full();
    test_redirect_drop();
    test_redirect_rvalid();
    test_push_pop();
    test_wrap();
    test_reset_midreq();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Parametrised instruction-fetch front end for the 5-stage pipelined CPU. It replaces the single-PC fetch stage with a PC generator, a single-outstanding instruction-memory request port and a DEPTH-entry in-order prefetch queue. It sits between instruction memory and the IF/ID pipeline register. It accepts the load-use stall and the MEM-stage branch/jump redirect, and presents one {PC, PC+4, instruction} word per cycle to ID.

## Interface
Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 0, first fetch address after reset; must be word-aligned.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Clrn  in  1  reset, asynchronous, active-low.
- stall  in  1  ID cannot accept this cycle (load-use stall).
- redirect  in  1  MEM-stage PCSrc; flush and refetch.
- redirect_pc  in  XLEN  branch/jump target; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  fetch request, valid for one cycle.
- imem_addr  out  XLEN  fetch address; word-aligned.
- imem_rvalid  in  1  response strobe; exactly one per request, in order, ≥1 cycle after the request.
- imem_rdata  in  32  fetched instruction.
- out_valid  out  1  queue head is valid.
- out_PC  out  XLEN  head PC; 0 when out_valid=0.
- out_PC4  out  XLEN  head PC+4; 0 when out_valid=0.
- out_Inst  out  32  head instruction; 0 (NOP) when out_valid=0.
- count  out  clog2(DEPTH+1)  queue occupancy.

## Operation
- State:
  - fpc: next fetch PC.
  - busy: one request outstanding.
  - drop: the outstanding response is to be discarded.
  - Circular queue with rd_ptr, wr_ptr and count; each entry holds {PC, Inst}.
- Issue:
  - Condition: imem_req = !redirect && (!busy || imem_rvalid) && (count + busy < DEPTH).
  - imem_addr = fpc.
  - On issue: fpc += 4 (wraps modulo 2^XLEN); busy <= 1.
- Response, when imem_rvalid:
  - If drop=1 or redirect=1: discard the response and clear drop.
  - Otherwise: push {PC of that request, imem_rdata}.
  - busy clears unless a new request issues in the same cycle.
  - The request PC is held in a register captured at issue.
- Pop: when out_valid && !stall && !redirect, rd_ptr advances.
- Push and pop in the same cycle: count is unchanged. Pointers wrap modulo DEPTH.
- Redirect has highest priority:
  - Queue empties (count <= 0, rd_ptr = wr_ptr).
  - fpc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - No request issues that cycle.
  - If busy && !imem_rvalid: drop <= 1.
- Full: no request issues while count + busy = DEPTH, so a push into a full queue never occurs.
- Empty: out_valid=0 and the outputs read zero, which gives ID a bubble.
- stall with an empty queue has no effect. Fetching continues under stall until the queue is full.

## Timing
- Reset values:
  - fpc=RESET_PC, busy=0, drop=0, count=0, pointers=0.
  - out_valid=0, out_PC/out_PC4/out_Inst=0, imem_req=0 while Clrn=0.
  - Reset mid-request abandons any outstanding response.
- First imem_req is asserted in the first cycle after Clrn deasserts.
- Latency: a response pushed at edge t drives out_valid=1 and head data from edge t onward, because outputs come from registered queue storage.
- With 1-cycle memory and no stall, sustained throughput is one instruction per cycle: a new request may issue in the same cycle as the response.
- Redirect asserted in cycle c:
  - out_valid=0 from edge c.
  - New-target request is issued in c+1 if the port is idle, or in the cycle the dropped response arrives otherwise.
  - The first target instruction appears one memory latency after that request.
- count, out_* and drop are registered. imem_req and imem_addr are combinational from state and inputs.

## Test plan
- Reset, RESET_PC=0x100, 1-cycle memory returning addr as data, no stall:
  - imem_addr sequence 0x100, 0x104, 0x108 on consecutive cycles.
  - out_PC 0x100/0x104/… each cycle, with out_PC4 = out_PC+4.
- stall held high, DEPTH=4:
  - count reaches 4, then imem_req stays 0.
  - On stall release, four consecutive pops in order, then fetching resumes at 0x110.
- 3-cycle memory latency, redirect to 0x203 one cycle after a request:
  - Late response discarded (drop set, then cleared).
  - Next imem_addr = 0x200; first valid out_PC = 0x200.
- redirect in the same cycle as imem_rvalid: response not pushed, drop stays 0, out_valid=0 the next cycle.
- Simultaneous push and pop at count=2: count stays 2 and head order is preserved.
- Fetch wrap: redirect to 0xFFFFFFFC, then fetch proceeds to 0x00000000, and out_PC4 of the 0xFFFFFFFC entry is 0.
- Clrn pulsed low mid-request: all outputs return to 0 immediately, a stale imem_rvalid after release is ignored, and fetch restarts at RESET_PC.
